// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with zero-tail termination.
// Accepts FRAME_LEN data bits, then flushes K-1 zero bits so the trellis
// ends in the all-zero state; one registered output stage with ready/valid.
module conv_encoder #(
  parameter int unsigned    K         = 5,
  parameter logic [K-1:0]   G0        = 5'b10011,
  parameter logic [K-1:0]   G1        = 5'b11101,
  parameter int unsigned    FRAME_LEN = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] out_sym,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BW = $clog2(FRAME_LEN + 1);
  localparam int unsigned TW = $clog2(K);
  localparam logic [BW-1:0] LAST_BIT   = BW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TAIL_LEN   = TW'(K - 1);
  localparam logic [TW-1:0] TAIL_FINAL = TW'(K - 2);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  state_t          state;
  logic [K-2:0]    sr;
  logic [BW-1:0]   bit_cnt;
  logic [TW-1:0]   tail_cnt;

  logic            slot_free;
  logic            data_push;
  logic            tail_push;
  logic            push;
  logic            new_bit;
  logic [K-1:0]    win;
  logic [1:0]      sym;

  // Output slot can take a new symbol when empty or being drained this cycle.
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == DATA) && slot_free;
  assign data_push = in_valid && in_ready;
  // Tail zeros are injected until all K-1 have been pushed, then we wait for
  // the final symbol to be taken.
  assign tail_push = (state == TAIL) && slot_free && (tail_cnt != TAIL_LEN);
  assign push      = data_push || tail_push;
  assign new_bit   = (state == DATA) ? in_bit : 1'b0;
  assign busy      = (state != IDLE);

  // Encoder window: newest bit at MSB, older history below it.
  assign win = {new_bit, sr};
  assign sym = {^(win & G0), ^(win & G1)};

  // Frame FSM, shift register, counters and the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      bit_cnt   <= '0;
      tail_cnt  <= '0;
      out_valid <= 1'b0;
      out_sym   <= 2'b00;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      if (slot_free) begin
        out_valid <= push;
        out_last  <= tail_push && (tail_cnt == TAIL_FINAL);
        if (push) begin
          out_sym <= sym;
        end
      end

      if (push) begin
        sr <= {new_bit, sr[K-2:1]};
      end

      case (state)
        IDLE: begin
          if (start) begin
            state    <= DATA;
            sr       <= '0;
            bit_cnt  <= '0;
            tail_cnt <= '0;
          end
        end
        DATA: begin
          if (data_push) begin
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) begin
              state    <= TAIL;
              tail_cnt <= '0;
            end
          end
        end
        TAIL: begin
          if (tail_push) begin
            tail_cnt <= tail_cnt + TW'(1);
          end else if ((tail_cnt == TAIL_LEN) && out_valid && out_ready && out_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: fixed vectors, stall/start/reset corner cases and
// randomized frames against a direct convolution model.
module tb_conv_encoder;

  localparam int unsigned K  = 5;
  localparam int unsigned FL = 4;
  localparam int unsigned NS = FL + K - 1;
  localparam logic [K-1:0] TG0 = 5'b10011;
  localparam logic [K-1:0] TG1 = 5'b11101;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_sym;
  logic       out_last;
  logic       out_ready;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  conv_encoder #(.K(K), .G0(TG0), .G1(TG1), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .out_valid(out_valid), .out_sym(out_sym),
    .out_last(out_last), .out_ready(out_ready), .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: symbol i is the parity of generator taps against x[i-j].
  function automatic logic [2*NS-1:0] ref_frame(input logic [FL-1:0] data);
    logic [2*NS-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NS); i++) begin
      logic s1, s0, xb;
      s1 = 1'b0;
      s0 = 1'b0;
      for (int j = 0; j < int'(K); j++) begin
        xb = (i - j >= 0 && i - j < int'(FL)) ? data[int'(FL) - 1 - (i - j)] : 1'b0;
        if (TG0[int'(K) - 1 - j]) s1 = s1 ^ xb;
        if (TG1[int'(K) - 1 - j]) s0 = s0 ^ xb;
      end
      r[2*(int'(NS) - 1 - i) +: 2] = {s1, s0};
    end
    return r;
  endfunction

  // Monitor: collects handshaked symbols, checks hold-under-stall and done timing.
  logic [2:0] got_q[$];
  logic       mon_stall   = 1'b0;
  logic       mon_last_hs = 1'b0;
  logic [2:0] mon_prev    = 3'b000;

  always @(negedge clk) begin
    if (rst) begin
      mon_stall   <= 1'b0;
      mon_last_hs <= 1'b0;
    end else begin
      if (mon_stall) check("hold", {28'd0, out_valid, out_last, out_sym}, {28'd0, 1'b1, mon_prev});
      if (mon_last_hs || done) check("done_pulse", {31'd0, done}, {31'd0, mon_last_hs});
      if (out_valid && out_ready) got_q.push_back({out_last, out_sym});
      mon_stall   <= out_valid && !out_ready;
      mon_prev    <= {out_last, out_sym};
      mon_last_hs <= out_valid && out_ready && out_last;
    end
  end

  // Drives one frame; entered at posedge+1, returns at posedge+1 or, when
  // chain_next is set, at the done negedge with start already raised.
  task automatic run_frame(input logic [FL-1:0] data, input int rdy_pct, input int stall_at,
                           input bit spam, input bit do_start, input bit chain_next,
                           output int ncyc);
    int  idx;
    bit  seen;
    got_q.delete();
    if (do_start) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx  = 0;
    seen = 1'b0;
    ncyc = 0;
    while (ncyc < 2000) begin
      in_valid  = (idx < int'(FL)) && (rdy_pct == 100 || $urandom_range(0, 99) < 70);
      in_bit    = in_valid ? data[int'(FL) - 1 - idx] : 1'($urandom_range(0, 1));
      out_ready = (ncyc >= stall_at && ncyc < stall_at + 5) ? 1'b0
                : ($urandom_range(0, 99) < rdy_pct);
      start     = spam && busy && ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (ncyc >= stall_at && ncyc < stall_at + 5 && out_valid)
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      if (idx == int'(FL) && in_ready) check("tail_in_ready", {31'd0, in_ready}, 32'd0);
      if (in_valid && in_ready) idx++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      ncyc++;
    end
    check("frame_done_seen", {31'd0, seen}, 32'd1);
    in_valid = 1'b0;
    if (chain_next) begin
      start = 1'b1;
    end else begin
      start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic compare_frame(input string name, input logic [2*NS-1:0] exp);
    logic [2*NS-1:0] gs;
    logic [NS-1:0]   gl;
    gs = '0;
    gl = '0;
    check({name, "_count"}, 32'(got_q.size()), 32'(NS));
    for (int i = 0; i < int'(NS); i++) begin
      if (i < got_q.size()) begin
        gs[2*(int'(NS) - 1 - i) +: 2] = got_q[i][1:0];
        gl[int'(NS) - 1 - i]           = got_q[i][2];
      end
    end
    check({name, "_syms"}, 32'(gs), 32'(exp));
    check({name, "_last"}, 32'(gl), 32'(1));
  endtask

  typedef struct {
    logic [FL-1:0]   bits;
    logic [2*NS-1:0] syms;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int   ncyc;
    logic [FL-1:0] d;

    tbl[0] = '{bits: 4'b1011, syms: 16'hD8F7};
    tbl[1] = '{bits: 4'b1000, syms: 16'hD6C0};
    tbl[2] = '{bits: 4'b0000, syms: 16'h0000};
    tbl[3] = '{bits: 4'b1111, syms: 16'hED47};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sym",   {30'd0, out_sym},   32'd0);
    check("rst_out_last",  {31'd0, out_last},  32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_done",      {31'd0, done},      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Fixed vectors at full rate: exact symbols and one-symbol-per-cycle rate.
    for (int v = 0; v < 4; v++) begin
      run_frame(tbl[v].bits, 100, -100, 1'b0, 1'b1, 1'b0, ncyc);
      compare_frame($sformatf("vec%0d", v), tbl[v].syms);
      check($sformatf("vec%0d_cycles", v), 32'(ncyc), 32'(NS + 1));
    end

    // Five-cycle downstream stall mid-frame must not change the sequence.
    run_frame(tbl[0].bits, 100, 3, 1'b0, 1'b1, 1'b0, ncyc);
    compare_frame("stall", tbl[0].syms);

    // Start pulses while busy are ignored.
    run_frame(tbl[3].bits, 100, -100, 1'b1, 1'b1, 1'b0, ncyc);
    compare_frame("spam", tbl[3].syms);

    // Start raised in the done cycle begins the next frame directly.
    run_frame(tbl[1].bits, 100, -100, 1'b0, 1'b1, 1'b1, ncyc);
    compare_frame("chain_a", tbl[1].syms);
    run_frame(tbl[0].bits, 100, -100, 1'b0, 1'b0, 1'b0, ncyc);
    compare_frame("chain_b", tbl[0].syms);

    // Reset while in the tail: frame dropped, no done, next frame from zero state.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < int'(FL); i++) begin
      in_bit = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy",      {31'd0, busy},      32'd0);
    check("mid_rst_done",      {31'd0, done},      32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle_busy", {31'd0, busy}, 32'd0);
      check("post_rst_idle_done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
    end
    run_frame(tbl[1].bits, 100, -100, 1'b0, 1'b1, 1'b0, ncyc);
    compare_frame("after_rst", tbl[1].syms);

    // Random data, backpressure and stray start pulses against the model.
    for (int f = 0; f < 1000; f++) begin
      d = FL'($urandom);
      run_frame(d, $urandom_range(30, 100), -100, 1'($urandom_range(0, 1)), 1'b1, 1'b0, ncyc);
      compare_frame($sformatf("rand%0d", f), ref_frame(d));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 SHALL have parameter K, default 5, constraint length (3..7).
REQ-002 SHALL have parameter G0, default 5'b10011, generator for out_sym[1], K bits.
REQ-003 SHALL have parameter G1, default 5'b11101, generator for out_sym[0], K bits.
REQ-004 SHALL have parameter FRAME_LEN, default 256, data bits per frame (>=1).
REQ-005 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port: start  input  1  one-cycle frame start request.
REQ-008 SHALL have port: in_valid  input  1  in_bit is valid.
REQ-009 SHALL have port: in_bit  input  1  data bit.
REQ-010 SHALL have port: in_ready  output  1  encoder accepts in_bit this cycle.
REQ-011 SHALL have port: out_valid  output  1  out_sym holds a symbol.
REQ-012 SHALL have port: out_sym  output  2  encoded symbol {g0 parity, g1 parity}.
REQ-013 SHALL have port: out_last  output  1  qualifies the final tail symbol of a frame.
REQ-014 SHALL have port: out_ready  input  1  downstream (channel/decoder) accepts symbol.
REQ-015 SHALL have port: busy  output  1  high in DATA and TAIL.
REQ-016 SHALL have port: done  output  1  one-cycle pulse after last symbol handshake.

Function
REQ-017 SHALL implement FSM states IDLE, DATA, TAIL.
REQ-018 IDLE: start=1 -> DATA, shift register sr (K-1 bits) cleared, bit counter cleared; start ignored in DATA/TAIL.
REQ-019 SHALL form window w = {b, sr[K-2:0]}, b newest bit at MSB; out_sym[1] = XOR-reduce(w & G0), out_sym[0] = XOR-reduce(w & G1).
REQ-020 On each accepted bit, sr SHALL update to {b, sr[K-2:1]}.
REQ-021 Output SHALL be a single registered stage: symbol for an accepted bit appears on out_sym with out_valid=1 the next cycle (latency 1).
REQ-022 Output register SHALL be free when out_valid=0 or out_ready=1; a bit is accepted only when the register is free.
REQ-023 In DATA, in_ready = output register free; accepted bit = in_valid & in_ready.
REQ-024 out_sym/out_valid/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 After the FRAME_LEN-th accepted bit, FSM SHALL go to TAIL; in_ready=0 in IDLE and TAIL.
REQ-026 TAIL SHALL inject K-1 zero bits through the same path, one per free output slot, no in_valid needed.
REQ-027 The last tail symbol SHALL carry out_last=1; all other symbols out_last=0.
REQ-028 On the out_last handshake, FSM SHALL return to IDLE and assert done for exactly that following cycle; busy falls in the same cycle.
REQ-029 start asserted in the cycle done is high SHALL start a new frame (IDLE accepts it).
REQ-030 Bit and tail counters SHALL be sized clog2(FRAME_LEN+1) and clog2(K) bits; no wrap-around within a frame.
REQ-031 With out_ready held 1 and in_valid held 1, throughput SHALL be one symbol per cycle including DATA->TAIL transition (no bubble).

Reset
REQ-032 rst=1 SHALL asynchronously force IDLE, sr=0, counters=0, out_valid=0, out_sym=2'b00, out_last=0, in_ready=0, busy=0, done=0.
REQ-033 rst mid-frame SHALL discard the frame and any pending symbol; no done pulse; new start required after release.

Verification
REQ-034 Defaults, start, bits 1,0 then zeros, out_ready=1 -> first symbols 2'b11, 2'b01.
REQ-035 FRAME_LEN=4, bits 1,0,1,1, out_ready=1 -> 8 symbols total, out_last only on 8th, done one cycle after it.
REQ-036 out_ready=0 for 5 cycles mid-frame -> out_sym stable, in_ready=0, no bit lost; sequence equals no-stall run.
REQ-037 start pulse while busy -> ignored; frame symbol count unchanged (FRAME_LEN+K-1).
REQ-038 rst asserted during TAIL -> next cycle out_valid=0, busy=0, done=0; next frame starts from sr=0 and matches golden model.
REQ-039 Random data/backpressure, 1000 frames -> symbols match reference encoder model and decode error-free through the team's Viterbi decoder.
